// File: rtl/comp_debounce.sv
// comp_debounce
//   Synchronizes and debounces five raw computer-on signals, then derives a
//   registered free-computer count, all-free / all-busy flags and a one-cycle
//   change strobe.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   comp_in    raw asynchronous inputs, bit i = computer i+1, 1 = busy
//   comps      debounced computer states (registered)
//   free_cnt   5 - popcount(comps) (registered)
//   all_free   comps == 5'b00000 (registered)
//   all_busy   comps == 5'b11111 (registered)
//   chg_pulse  high for the cycle following any edge on which comps changed
module comp_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] comp_in,
    output logic [4:0] comps,
    output logic [2:0] free_cnt,
    output logic       all_free,
    output logic       all_busy,
    output logic       chg_pulse
);

    localparam int unsigned CW = ($clog2(DEB_CYCLES + 1) > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [CW-1:0] cnt     [5];
    logic [CW-1:0] cnt_nxt [5];
    logic [4:0]    comps_nxt;
    logic [2:0]    busy_nxt;

    // Next-state of every channel is resolved here so the derived outputs can
    // be registered from comps_nxt and stay aligned with comps.
    always_comb begin
        comps_nxt = comps;
        busy_nxt  = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != comps[i]) begin
                if (cnt[i] == TERM) begin
                    comps_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        for (int unsigned i = 0; i < 5; i++) begin
            busy_nxt = busy_nxt + {2'b00, comps_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
            comps     <= '0;
            free_cnt  <= 3'd5;
            all_free  <= 1'b1;
            all_busy  <= 1'b0;
            chg_pulse <= 1'b0;
        end else begin
            sync1     <= comp_in;
            sync2     <= sync1;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            comps     <= comps_nxt;
            free_cnt  <= 3'd5 - busy_nxt;
            all_free  <= (comps_nxt == 5'b00000);
            all_busy  <= (comps_nxt == 5'b11111);
            chg_pulse <= (comps_nxt != comps);
        end
    end

endmodule

// File: tb/tb_comp_debounce.sv
// tb_comp_debounce
//   Directed-vector bench for comp_debounce: one instance with DEB_CYCLES=4
//   and one with DEB_CYCLES=1, sharing a clock, each with its own inputs.
module tb_comp_debounce;

    logic       clk = 1'b0;
    logic       rst4, rst1;
    logic [4:0] in4, in1;
    logic [4:0] comps4, comps1;
    logic [2:0] free4, free1;
    logic       af4, af1, ab4, ab1, chg4, chg1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_debounce #(.DEB_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4), .comp_in(in4), .comps(comps4),
        .free_cnt(free4), .all_free(af4), .all_busy(ab4), .chg_pulse(chg4)
    );

    comp_debounce #(.DEB_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .comp_in(in1), .comps(comps1),
        .free_cnt(free1), .all_free(af1), .all_busy(ab1), .chg_pulse(chg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset4;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
    endtask

    task automatic chk4(input string tag, input logic [4:0] c, input logic [2:0] f,
                        input logic a_f, input logic a_b, input logic p);
        check({tag, ".comps"},     {27'd0, comps4}, {27'd0, c});
        check({tag, ".free_cnt"},  {29'd0, free4},  {29'd0, f});
        check({tag, ".all_free"},  {31'd0, af4},    {31'd0, a_f});
        check({tag, ".all_busy"},  {31'd0, ab4},    {31'd0, a_b});
        check({tag, ".chg_pulse"}, {31'd0, chg4},   {31'd0, p});
    endtask

    initial begin
        rst4 = 1'b1; rst1 = 1'b1; in4 = '0; in1 = '0;
        tick();
        tick();
        rst4 = 1'b0;
        rst1 = 1'b0;

        // Reset state
        reset4();
        chk4("reset", 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);

        // Single channel rise: flip on edge 6, one-cycle strobe
        in4 = 5'b00001;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk4($sformatf("rise_e%0d", e), 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk4("rise_e6", 5'b00001, 3'd4, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("rise_e7", 5'b00001, 3'd4, 1'b0, 1'b0, 1'b0);

        // Glitch on channel 2 lasting 3 cycles is rejected
        in4 = 5'b00101;
        tick(); tick(); tick();
        in4 = 5'b00001;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk4($sformatf("glitch_e%0d", e), 5'b00001, 3'd4, 1'b0, 1'b0, 1'b0);
        end
        // Counter must have restarted from 0: full latency again
        in4 = 5'b00101;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("glitch_restart_e%0d.comps", e), {27'd0, comps4}, 32'h01);
        end
        tick();
        chk4("glitch_restart_e6", 5'b00101, 3'd3, 1'b0, 1'b0, 1'b1);

        // All channels at once
        reset4();
        chk4("all_reset", 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
        in4 = 5'b11111;
        for (int e = 1; e <= 5; e++) begin
            tick();
        end
        check("all_e5.comps", {27'd0, comps4}, 32'h00);
        tick();
        chk4("all_e6", 5'b11111, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("all_e7", 5'b11111, 3'd0, 1'b0, 1'b1, 1'b0);

        // Reset mid-debounce at edge 4 discards progress
        reset4();
        in4 = 5'b00010;
        tick(); tick(); tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk4("mid_rst_e4", 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("mid_rst_rel_e%0d.comps", e), {27'd0, comps4}, 32'h00);
        end
        tick();
        chk4("mid_rst_rel_e6", 5'b00010, 3'd4, 1'b0, 1'b0, 1'b1);

        // Reset beats a flip due on the same edge
        reset4();
        in4 = 5'b01000;
        for (int e = 1; e <= 5; e++) begin
            tick();
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk4("rst_prio", 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);

        // Staggered rises produce back-to-back strobes
        reset4();
        in4 = 5'b00001;
        tick();
        in4 = 5'b00011;
        for (int e = 2; e <= 5; e++) begin
            tick();
        end
        chk4("stag_e5", 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk4("stag_e6", 5'b00001, 3'd4, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("stag_e7", 5'b00011, 3'd3, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("stag_e8", 5'b00011, 3'd3, 1'b0, 1'b0, 1'b0);

        // DEB_CYCLES=1: flip on edge 3, one-cycle dip follows through
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("d1_reset.free_cnt", {29'd0, free1}, 32'd5);
        in1 = 5'b10000;
        tick(); tick();
        check("d1_e2.comps", {27'd0, comps1}, 32'h00);
        tick();
        check("d1_e3.comps", {27'd0, comps1}, 32'h10);
        check("d1_e3.chg_pulse", {31'd0, chg1}, 32'd1);
        check("d1_e3.free_cnt", {29'd0, free1}, 32'd4);
        in1 = 5'b00000;
        tick();
        in1 = 5'b10000;
        tick();
        check("d1_dip_e2.comps", {27'd0, comps1}, 32'h10);
        check("d1_dip_e2.chg_pulse", {31'd0, chg1}, 32'd0);
        tick();
        check("d1_dip_e3.comps", {27'd0, comps1}, 32'h00);
        check("d1_dip_e3.chg_pulse", {31'd0, chg1}, 32'd1);
        check("d1_dip_e3.all_free", {31'd0, af1}, 32'd1);
        tick();
        check("d1_dip_e4.comps", {27'd0, comps1}, 32'h10);
        check("d1_dip_e4.chg_pulse", {31'd0, chg1}, 32'd1);
        tick();
        check("d1_dip_e5.chg_pulse", {31'd0, chg1}, 32'd0);
        check("d1_dip_e5.all_busy", {31'd0, ab1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
